// File: rtl/cochlea_ch_ctrl.sv
// ---------------------------------------------------------------------------
// cochlea_ch_ctrl
//
// Digital sequencer for one I or Q analog filter channel. It generates the
// channel clocks (cclk, div2) and the LO, samples the comparator on each
// rising edge of the analog phase clock to drive the filter feedback bit,
// and counts comparator "high" events per frame. Each frame count is handed
// to the digital core over a valid/ready port.
//
// Optional build macro:
//   EVT_SATURATE_EN - when defined, the per-frame event counter and the
//                     reported result saturate at 2^CNT_W-1. When undefined,
//                     they wrap modulo 2^CNT_W.
//
// Parameters:
//   DIV_W - width of the cclk half-period divider ratio
//   FRM_W - width of the frame length, in phi1b_dig rising edges
//   CNT_W - width of the event counter
//   Q_CH  - 0: I channel (lo equals div2), 1: Q channel (lo in quadrature)
//
// Ports:
//   clk        core clock; all state changes on the rising edge
//   rstb       asynchronous active-low reset
//   en         run request (level)
//   div_ratio  cclk half-period minus 1, in clk cycles; captured on IDLE->RUN
//   frame_len  phi1b_dig edges per frame; captured on IDLE->RUN; 0 acts as 1
//   high_buf   comparator output, asynchronous to clk
//   phi1b_dig  analog phase clock, asynchronous to clk
//   cclk       channel clock to the phi clock generator
//   div2       cclk/2 to the phi clock generator
//   lo         local oscillator to the LO mux
//   fb1        filter feedback bit
//   evt_count  event count of the last completed frame
//   evt_valid  evt_count holds an unconsumed result
//   evt_ready  consumer accepts evt_count
//   evt_ovf    sticky flag: a frame result was dropped
//   busy       sequencer is not idle
// ---------------------------------------------------------------------------
module cochlea_ch_ctrl #(
    parameter int DIV_W = 8,
    parameter int FRM_W = 10,
    parameter int CNT_W = 10,
    parameter int Q_CH  = 0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic [FRM_W-1:0] frame_len,
    input  logic             high_buf,
    input  logic             phi1b_dig,
    output logic             cclk,
    output logic             div2,
    output logic             lo,
    output logic             fb1,
    output logic [CNT_W-1:0] evt_count,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Synchronizer chains for the two asynchronous analog inputs.
    logic hb_s1_q, hb_s1_d;
    logic hb_s_q,  hb_s_d;
    logic ph_s1_q, ph_s1_d;
    logic ph_s_q,  ph_s_d;
    logic ph_d_q,  ph_d_d;

    // Configuration captured when a run starts.
    logic [DIV_W-1:0] div_ratio_q, div_ratio_d;
    logic [FRM_W-1:0] frame_len_q, frame_len_d;

    // Divider, frame and event counters.
    logic [DIV_W-1:0] dcnt_q, dcnt_d;
    logic [FRM_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    // Registered outputs.
    logic             cclk_q, cclk_d;
    logic             div2_q, div2_d;
    logic             lo_q,   lo_d;
    logic             fb1_q,  fb1_d;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_ovf_q,   evt_ovf_d;
    logic             busy_q,      busy_d;

    // Combinational helpers.
    logic             p_s;
    logic             tick_s;
    logic             frame_end_s;
    logic             load_ok_s;
    logic [CNT_W-1:0] ecnt_inc_s;
    logic [DIV_W-1:0] div_dcnt_s;
    logic             div_cclk_s;
    logic             div2_nx_s;
    logic             lo_nx_s;

    // Adds one comparator sample to the event count, wrapping or saturating.
    function automatic logic [CNT_W-1:0] evt_inc(input logic [CNT_W-1:0] c,
                                                 input logic             b);
`ifdef EVT_SATURATE_EN
        if (b && (c != {CNT_W{1'b1}})) begin
            evt_inc = c + CNT_W'(1);
        end else begin
            evt_inc = c;
        end
`else
        evt_inc = c + CNT_W'(b);
`endif
    endfunction

    // Next-state logic for the sequencer, divider, feedback and result port.
    always_comb begin
        state_d     = state_q;
        div_ratio_d = div_ratio_q;
        frame_len_d = frame_len_q;
        dcnt_d      = dcnt_q;
        pcnt_d      = pcnt_q;
        ecnt_d      = ecnt_q;
        cclk_d      = cclk_q;
        div2_d      = div2_q;
        lo_d        = lo_q;
        fb1_d       = fb1_q;
        evt_count_d = evt_count_q;
        evt_ovf_d   = evt_ovf_q;

        hb_s1_d = high_buf;
        hb_s_d  = hb_s1_q;
        ph_s1_d = phi1b_dig;
        ph_s_d  = ph_s1_q;
        ph_d_d  = ph_s_q;

        // One-cycle pulse per synchronized phi1b_dig rising edge.
        p_s = ph_s_q & ~ph_d_q;

        // Divider: cclk toggles every div_ratio_q+1 clk cycles.
        tick_s = (dcnt_q == div_ratio_q);
        if (tick_s) begin
            div_dcnt_s = {DIV_W{1'b0}};
        end else begin
            div_dcnt_s = dcnt_q + DIV_W'(1);
        end
        div_cclk_s = cclk_q ^ tick_s;
        // div2 advances on cclk rising; the Q-channel lo advances on cclk
        // falling, which puts it a quarter div2 period behind.
        div2_nx_s = div2_q ^ (tick_s & ~cclk_q);
        if (Q_CH == 0) begin
            lo_nx_s = div2_nx_s;
        end else begin
            lo_nx_s = lo_q ^ (tick_s & cclk_q);
        end

        frame_end_s = (pcnt_q == (frame_len_q - FRM_W'(1)));
        load_ok_s   = ~evt_valid_q | evt_ready;
        ecnt_inc_s  = evt_inc(ecnt_q, hb_s_q);

        // An accepted result retires unless a new frame overwrites it below.
        if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end else begin
            evt_valid_d = evt_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                cclk_d = 1'b0;
                div2_d = 1'b0;
                lo_d   = 1'b0;
                fb1_d  = 1'b0;
                if (en) begin
                    state_d     = ST_RUN;
                    div_ratio_d = div_ratio;
                    frame_len_d = (frame_len == {FRM_W{1'b0}}) ? FRM_W'(1) : frame_len;
                    dcnt_d      = {DIV_W{1'b0}};
                    pcnt_d      = {FRM_W{1'b0}};
                    ecnt_d      = {CNT_W{1'b0}};
                    evt_ovf_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                dcnt_d = div_dcnt_s;
                cclk_d = div_cclk_s;
                div2_d = div2_nx_s;
                lo_d   = lo_nx_s;
                if (p_s) begin
                    fb1_d = hb_s_q;
                    if (frame_end_s) begin
                        ecnt_d = {CNT_W{1'b0}};
                        pcnt_d = {FRM_W{1'b0}};
                        if (load_ok_s) begin
                            evt_count_d = ecnt_inc_s;
                            evt_valid_d = 1'b1;
                        end else begin
                            evt_ovf_d = 1'b1;
                        end
                    end else begin
                        ecnt_d = ecnt_inc_s;
                        pcnt_d = pcnt_q + FRM_W'(1);
                    end
                end else begin
                    fb1_d = fb1_q;
                end
                if (!en) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                // Keep dividing until cclk is low so its high phase is never cut short.
                dcnt_d = div_dcnt_s;
                cclk_d = div_cclk_s;
                div2_d = div2_nx_s;
                lo_d   = lo_nx_s;
                if (!div_cclk_s) begin
                    state_d = ST_IDLE;
                    div2_d  = 1'b0;
                    lo_d    = 1'b0;
                    fb1_d   = 1'b0;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cclk_d  = 1'b0;
                div2_d  = 1'b0;
                lo_d    = 1'b0;
                fb1_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, synchronizer and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            hb_s1_q     <= 1'b0;
            hb_s_q      <= 1'b0;
            ph_s1_q     <= 1'b0;
            ph_s_q      <= 1'b0;
            ph_d_q      <= 1'b0;
            div_ratio_q <= {DIV_W{1'b0}};
            frame_len_q <= {FRM_W{1'b0}};
            dcnt_q      <= {DIV_W{1'b0}};
            pcnt_q      <= {FRM_W{1'b0}};
            ecnt_q      <= {CNT_W{1'b0}};
            cclk_q      <= 1'b0;
            div2_q      <= 1'b0;
            lo_q        <= 1'b0;
            fb1_q       <= 1'b0;
            evt_count_q <= {CNT_W{1'b0}};
            evt_valid_q <= 1'b0;
            evt_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hb_s1_q     <= hb_s1_d;
            hb_s_q      <= hb_s_d;
            ph_s1_q     <= ph_s1_d;
            ph_s_q      <= ph_s_d;
            ph_d_q      <= ph_d_d;
            div_ratio_q <= div_ratio_d;
            frame_len_q <= frame_len_d;
            dcnt_q      <= dcnt_d;
            pcnt_q      <= pcnt_d;
            ecnt_q      <= ecnt_d;
            cclk_q      <= cclk_d;
            div2_q      <= div2_d;
            lo_q        <= lo_d;
            fb1_q       <= fb1_d;
            evt_count_q <= evt_count_d;
            evt_valid_q <= evt_valid_d;
            evt_ovf_q   <= evt_ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign cclk      = cclk_q;
    assign div2      = div2_q;
    assign lo        = lo_q;
    assign fb1       = fb1_q;
    assign evt_count = evt_count_q;
    assign evt_valid = evt_valid_q;
    assign evt_ovf   = evt_ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cochlea_ch_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for cochlea_ch_ctrl: an I-channel instance (main), a Q-channel
// instance sharing all inputs, and a CNT_W=2 instance with its own enable.
// Frame results are checked through scoreboard queues popped by monitors.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cochlea_ch_ctrl;

    localparam int DIV_W = 8;
    localparam int FRM_W = 10;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic             en = 1'b0;
    logic             en_c = 1'b0;
    logic [DIV_W-1:0] div_ratio = 8'd0;
    logic [FRM_W-1:0] frame_len = 10'd0;
    logic             high_buf = 1'b0;
    logic             phi1b_dig = 1'b0;
    logic             evt_ready = 1'b0;

    logic             cclk, div2, lo, fb1, evt_valid, evt_ovf, busy;
    logic [CNT_W-1:0] evt_count;
    logic             q_cclk, q_div2, q_lo, q_fb1, q_evt_valid, q_evt_ovf, q_busy;
    logic [CNT_W-1:0] q_evt_count;
    logic             c_cclk, c_div2, c_lo, c_fb1, c_evt_valid, c_evt_ovf, c_busy;
    logic [1:0]       c_evt_count;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_c[$];
    logic fb_model = 1'b0;

    // Measurement scratch for the clock checks.
    int   c_r[2];
    int   d_r[2];
    int   q_r;
    int   nc, nd, lo_bad, n;
    logic pc, pd, pq;

    always #5 clk = ~clk;

    cochlea_ch_ctrl #(.DIV_W(DIV_W), .FRM_W(FRM_W), .CNT_W(CNT_W), .Q_CH(0)) dut (
        .clk(clk), .rstb(rstb), .en(en), .div_ratio(div_ratio), .frame_len(frame_len),
        .high_buf(high_buf), .phi1b_dig(phi1b_dig), .cclk(cclk), .div2(div2), .lo(lo),
        .fb1(fb1), .evt_count(evt_count), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_ovf(evt_ovf), .busy(busy)
    );

    cochlea_ch_ctrl #(.DIV_W(DIV_W), .FRM_W(FRM_W), .CNT_W(CNT_W), .Q_CH(1)) dut_q (
        .clk(clk), .rstb(rstb), .en(en), .div_ratio(div_ratio), .frame_len(frame_len),
        .high_buf(high_buf), .phi1b_dig(phi1b_dig), .cclk(q_cclk), .div2(q_div2), .lo(q_lo),
        .fb1(q_fb1), .evt_count(q_evt_count), .evt_valid(q_evt_valid), .evt_ready(evt_ready),
        .evt_ovf(q_evt_ovf), .busy(q_busy)
    );

    cochlea_ch_ctrl #(.DIV_W(DIV_W), .FRM_W(FRM_W), .CNT_W(2), .Q_CH(0)) dut_c (
        .clk(clk), .rstb(rstb), .en(en_c), .div_ratio(div_ratio), .frame_len(frame_len),
        .high_buf(high_buf), .phi1b_dig(phi1b_dig), .cclk(c_cclk), .div2(c_div2), .lo(c_lo),
        .fb1(c_fb1), .evt_count(c_evt_count), .evt_valid(c_evt_valid), .evt_ready(evt_ready),
        .evt_ovf(c_evt_ovf), .busy(c_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges, then step off the edge.
    task automatic tick(input int cnt);
        repeat (cnt) @(posedge clk);
        #1;
    endtask

    // One phi1b_dig pulse carrying comparator value v; optionally checks fb1 latency.
    task automatic pulse(input logic v, input logic chk);
        tick(1);
        high_buf  = v;
        phi1b_dig = 1'b1;
        tick(2);
        if (chk) check("fb1_hold", 32'(fb1), 32'(fb_model));
        tick(1);
        if (chk) begin
            check("fb1", 32'(fb1), 32'(v));
            fb_model = v;
        end
        tick(2);
        phi1b_dig = 1'b0;
        tick(4);
    endtask

    task automatic wait_idle();
        int k;
        k  = 0;
        en = 1'b0;
        while (busy && k < 50) begin
            tick(1);
            k++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        fb_model = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cclk"},  32'(cclk),      32'd0);
        check({tag, "_div2"},  32'(div2),      32'd0);
        check({tag, "_lo"},    32'(lo),        32'd0);
        check({tag, "_fb1"},   32'(fb1),       32'd0);
        check({tag, "_valid"}, 32'(evt_valid), 32'd0);
        check({tag, "_count"}, 32'(evt_count), 32'd0);
        check({tag, "_ovf"},   32'(evt_ovf),   32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    // Monitor for the main instance: every accepted result is popped and compared.
    always @(negedge clk) begin
        if (rstb && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got count %0d with no expected result", evt_count);
            end else begin
                checks--;
                check("evt_count", 32'(evt_count), 32'(exp_q.pop_front()));
            end
        end
    end

    // Monitor for the narrow-counter instance.
    always @(negedge clk) begin
        if (rstb && c_evt_valid && evt_ready) begin
            checks++;
            if (exp_c.size() == 0) begin
                errors++;
                $display("FAIL c_evt_unexpected: got count %0d with no expected result", c_evt_count);
            end else begin
                checks--;
                check("c_evt_count", 32'(c_evt_count), 32'(exp_c.pop_front()));
            end
        end
    end

    initial begin
        // Reset state.
        tick(3);
        check_all_zero("rst");
        rstb = 1'b1;
        tick(2);
        check_all_zero("post_rst");

        // Clock generation: div_ratio=2 -> cclk period 6, div2 period 12.
        div_ratio = 8'd2;
        frame_len = 10'd4;
        evt_ready = 1'b1;
        en        = 1'b1;
        nc = 0; nd = 0; q_r = -1; lo_bad = 0;
        c_r[0] = 0; c_r[1] = 0; d_r[0] = 0; d_r[1] = 0;
        pc = 1'b0; pd = 1'b0; pq = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cclk && !pc && nc < 2) begin c_r[nc] = i; nc++; end
            if (div2 && !pd && nd < 2) begin d_r[nd] = i; nd++; end
            if (q_lo && !pq && q_r < 0) q_r = i;
            if (lo !== div2) lo_bad++;
            pc = cclk; pd = div2; pq = q_lo;
        end
        check("cclk_rises",   32'(nc), 32'd2);
        check("div2_rises",   32'(nd), 32'd2);
        check("cclk_period",  32'(c_r[1] - c_r[0]), 32'd6);
        check("div2_period",  32'(d_r[1] - d_r[0]), 32'd12);
        check("lo_eq_div2",   32'(lo_bad), 32'd0);
        check("q_lo_lag",     32'(q_r - d_r[0]), 32'd3);
        tick(1);
        check("busy_run",     32'(busy), 32'd1);

        // Frame 1,0,1,1 with ready high -> one result of 3.
        exp_q.push_back(3);
        pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        tick(3);

        // Ready low across two frames (3 then 2): second is dropped.
        evt_ready = 1'b0;
        exp_q.push_back(3);
        pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        tick(3);
        check("held_valid", 32'(evt_valid), 32'd1);
        check("held_count", 32'(evt_count), 32'd3);
        check("ovf_set",    32'(evt_ovf),   32'd1);
        evt_ready = 1'b1;
        tick(2);
        check("valid_clear", 32'(evt_valid), 32'd0);

        // Overflow flag survives idle and clears on the next start; frame_len=0 acts as 1.
        wait_idle();
        check("ovf_kept_idle", 32'(evt_ovf), 32'd1);
        div_ratio = 8'd5;
        frame_len = 10'd0;
        en        = 1'b1;
        tick(2);
        check("ovf_cleared", 32'(evt_ovf), 32'd0);
        exp_q.push_back(1);
        pulse(1'b1, 1'b1);
        exp_q.push_back(0);
        pulse(1'b0, 1'b1);

        // Stop with cclk just risen: cclk stays high its full 6 cycles.
        n = 0;
        while (cclk !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        while (cclk !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("cclk_rise_seen", 32'(cclk), 32'd1);
        en = 1'b0;
        n  = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stop_cycles", 32'(n), 32'd6);
        check("stop_cclk",   32'(cclk), 32'd0);
        check("stop_div2",   32'(div2), 32'd0);
        check("stop_lo",     32'(lo),   32'd0);
        check("stop_fb1",    32'(fb1),  32'd0);
        check("stop_q_lo",   32'(q_lo), 32'd0);
        fb_model = 1'b0;
        tick(1);

        // CNT_W=2 instance: six high samples per frame.
        frame_len = 10'd6;
        high_buf  = 1'b1;
        tick(1);
        en_c = 1'b1;
        tick(1);
`ifdef EVT_SATURATE_EN
        exp_c.push_back(3);
`else
        exp_c.push_back(2);
`endif
        for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0);
        en_c = 1'b0;
        tick(12);

        // Asynchronous reset mid-run with cclk high and a pending result.
        div_ratio = 8'd2;
        frame_len = 10'd1;
        evt_ready = 1'b0;
        en        = 1'b1;
        tick(2);
        pulse(1'b1, 1'b1);
        n = 0;
        while (cclk !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("pre_rst_cclk",  32'(cclk),      32'd1);
        check("pre_rst_valid", 32'(evt_valid), 32'd1);
        check("pre_rst_count", 32'(evt_count), 32'd1);
        #2;
        rstb = 1'b0;
        #1;
        check_all_zero("async_rst");
        en = 1'b0;
        #3;
        rstb = 1'b1;
        tick(3);
        check_all_zero("after_async");

        check("queue_main_empty", 32'(exp_q.size()), 32'd0);
        check("queue_c_empty",    32'(exp_c.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cochlea_ch_ctrl.md
Name: cochlea_ch_ctrl

Overview:
- Digital sequencer for one I or Q analog filter channel.
- Generates the channel clocks (cclk, div2) and the LO for the phi clkgen and LO mux.
- Samples the comparator output on phi1b_dig edges to drive filter feedback (fb1).
- Accumulates comparator "high" events per frame and hands the counts to the digital core over a valid/ready port.
- Lives in the digital core. Outputs go to the analog core's level shifters; inputs come from its vccd-domain outputs.

Parameters:
- DIV_W, 8, width of the cclk half-period divider ratio
- FRM_W, 10, width of frame length, in phi1b_dig edges
- CNT_W, 10, width of the event counter
- Q_CH, 0, 0 = I channel (lo in phase with div2), 1 = Q channel (lo in quadrature)

Ports:
- clk  input  1  core clock; all state on rising edge
- rstb  input  1  asynchronous active-low reset
- en  input  1  run request, level
- div_ratio  input  DIV_W  cclk half-period minus 1, in clk cycles; captured on IDLE->RUN
- frame_len  input  FRM_W  phi1b_dig edges per frame; captured on IDLE->RUN; 0 treated as 1
- high_buf  input  1  comparator output, asynchronous to clk
- phi1b_dig  input  1  analog phase clock, asynchronous to clk
- cclk  output  1  channel clock to phi clkgen
- div2  output  1  cclk/2 to phi clkgen
- lo  output  1  local oscillator to LO mux
- fb1  output  1  filter feedback bit
- evt_count  output  CNT_W  event count of last completed frame
- evt_valid  output  1  evt_count is valid
- evt_ready  input  1  consumer accepts evt_count
- evt_ovf  output  1  sticky: a frame was dropped
- busy  output  1  state != IDLE

Behaviour:
- Reset (rstb=0): state=IDLE; all outputs 0; all counters 0.
- high_buf and phi1b_dig each pass through a 2-flop synchronizer (hb_s, ph_s). A third flop on ph_s gives ph_d.
- Edge pulse: p = ph_s & ~ph_d. This gives 3 clk edges from phi1b_dig rising to fb1 update.
- FSM IDLE -> RUN when en=1. Captures div_ratio and frame_len; clears divider, frame and event counters.
- In IDLE: cclk, div2, lo and fb1 are held 0; p is ignored.
- RUN -> STOP when en=0.
- STOP -> IDLE when cclk=0 at the end of the cycle. cclk is never truncated high; a partial frame is discarded.
- en re-asserted during STOP does not abort STOP. The FSM enters IDLE, then RUN on the following cycle.
- Divider (RUN and STOP):
  - If dcnt==div_ratio_q: dcnt<=0 and cclk toggles; otherwise dcnt increments.
  - cclk half-period = div_ratio_q+1 clk cycles.
  - div2 toggles on the clk edge where cclk goes 0->1.
  - Q_CH=0: lo==div2.
  - Q_CH=1: lo toggles on the clk edge where cclk goes 1->0.
- Feedback (RUN only): on p, fb1<=hb_s. ecnt increments by hb_s, wrapping mod 2^CNT_W. pcnt increments.
- Frame end: on p with pcnt==frame_len_q-1:
  - result = ecnt+hb_s is formed; ecnt<=0 and pcnt<=0.
  - If evt_valid=0, or evt_valid&evt_ready in the same cycle: evt_count<=result and evt_valid<=1.
  - Otherwise evt_count is held, the result is dropped and evt_ovf<=1.
- Handshake: evt_valid&evt_ready clears evt_valid next cycle unless a new frame loads in that same cycle.
- evt_valid and evt_count survive STOP/IDLE until accepted.
- evt_ovf is cleared only by reset or by the IDLE->RUN transition.

Optional Feature:
- Macro EVT_SATURATE_EN.
- Defined: ecnt saturates at 2^CNT_W-1 instead of wrapping; result also saturates.
- Undefined: modular wrap.

Test Plan:
- rstb pulsed low mid-RUN with cclk=1 -> all outputs 0 immediately, asynchronously; state IDLE.
- en=1, div_ratio=2, Q_CH=0 -> cclk period 6 clk; div2 period 12 clk; lo==div2. With Q_CH=1, lo lags div2 by 3 clk.
- frame_len=4, high_buf=1,0,1,1 at successive phi1b_dig rises, evt_ready=1 -> fb1 follows 1,0,1,1 with 3-clk latency; evt_valid pulses once with evt_count=3.
- evt_ready=0 across two completed frames (counts 3 then 2) -> evt_count stays 3; evt_ovf=1. Then evt_ready=1 -> evt_valid clears.
- en dropped when cclk=1, div_ratio=5 -> busy stays 1 until cclk falls (<=6 clk); then IDLE with div2=lo=fb1=0.
- CNT_W=2, frame_len=6, high_buf=1 constantly -> evt_count=2 (wrap) without the macro; 3 with EVT_SATURATE_EN.
